cnt_multi_timer: RTL and testbench
==================================

# cnt_multi_timer

Multi-channel timebase counter: one shared, runtime-programmable prescaler drives N_CH independent tick counters. Each channel has enable, clear, compare match, free-run or auto-reload mode, and a sticky overflow flag. An atomic snapshot port latches all channel values in one cycle for coherent software reads. It sits beside the board's clock-cycle counter and provides multiple programmable timers and periodic interrupt sources to the CPU-side register block.

## Interface
- CNT_W, 32: channel counter width.
- PRE_W, 16: prescaler divider width.
- N_CH, 4: number of channels (1..16).
- cnt_clk  in  1  sole clock; all logic on posedge.
- cnt_reset  in  1  synchronous, active-high reset.
- cfg_div  in  PRE_W  prescale divider; one tick every cfg_div+1 cycles.
- ch_en  in  N_CH  per-channel count enable.
- ch_clr  in  N_CH  per-channel clear (level, sampled each cycle).
- ch_mode  in  N_CH  0 = free-run with wrap, 1 = auto-reload on compare.
- ch_cmp  in  N_CH*CNT_W  per-channel compare value; channel i at [i*CNT_W +: CNT_W].
- tick  out  1  one-cycle pulse, registered, aligned with counter updates.
- ch_val  out  N_CH*CNT_W  current channel values.
- ch_match  out  N_CH  one-cycle compare pulse per channel.
- ch_ovf  out  N_CH  sticky wrap flag per channel.
- snap_req  in  1  snapshot request.
- snap_valid  out  1  snapshot held.
- snap_data  out  N_CH*CNT_W  latched channel values.
- snap_ack  in  1  consumes the snapshot.

## Operation
- Reset (cnt_reset=1 at an edge): prescaler, tick, ch_val, ch_match, ch_ovf, snap_valid, and snap_data all go to 0.
- Prescaler: pre_cnt increments each cycle. hit = (pre_cnt >= cfg_div). On hit, pre_cnt goes to 0. The >= compare makes a cfg_div decrease below the current pre_cnt take effect on the next cycle. cfg_div=0 gives hit every cycle.
- Channel i on each edge, in priority order:
  - ch_clr[i]: val=0, ovf=0, no match. This wins over tick and enable.
  - Else if hit && ch_en[i], mode 0: val=val+1, mod 2^CNT_W. If val was all-ones, ovf is set. match=1 iff val+1 == cmp.
  - Else if hit && ch_en[i], mode 1: if val == cmp, val=0 and match=1; else val=val+1 and match=0. Wrap in mode 1 (cmp below val after a cmp change) sets ovf as in mode 0.
  - Otherwise: val holds and match=0.
- A mode 1 channel with cmp=K has period K+1 ticks.
- ch_ovf is cleared only by ch_clr or reset.
- Snapshot: snap_req with snap_valid=0 loads snap_data with the next-state values of all channels, i.e. the values ch_val shows in the following cycle. This keeps the snapshot coherent with a concurrent tick.
- snap_valid stays 1 until the edge at which snap_ack=1, then clears. snap_data holds its value while valid.
- snap_req while snap_valid=1 is ignored, including in the same cycle as snap_ack. snap_ack while snap_valid=0 is ignored.

## Timing
- tick registers hit, so tick=1 in exactly the cycles where updated ch_val first appears.
- ch_match is registered and asserts in the same cycle as the matching ch_val.
- First tick after reset release: cycle cfg_div+1, counting the first non-reset edge as cycle 1.
- Snapshot latency: snap_valid and snap_data visible 1 cycle after snap_req.
- ch_clr to ch_val=0: 1 cycle.
- Reset mid-snapshot drops snap_valid. Reset mid-period restarts the prescaler.
- No combinational input-to-output paths.

## Structure
- Package cnt_pkg:
  - Mode encodings CNT_MODE_FREE=1'b0 and CNT_MODE_RELOAD=1'b1.
  - Default width localparams.
  - A channel-slice helper function.
- Sub-module cnt_prescaler (cnt_clk, cnt_reset, cfg_div → hit) holds the divider. Channels are a generate loop in the top module.

## Test plan
- Reset, cfg_div=3, ch_en=4'b0001, mode 0 → tick on cycles 4, 8, 12; ch_val[0] shows 1, 2, 3 at those cycles; other channels stay 0.
- cfg_div=0, mode 1, cmp=2 → ch_val sequence 1, 2, 0, 1, 2, 0; ch_match pulses on every 0; ch_ovf stays 0.
- Mode 0, channel preset near max by running CNT_W=8 with cfg_div=0 → value goes 255 → 0, ch_ovf=1 and stays 1 until ch_clr. ch_clr and tick in the same cycle → val=0, no match.
- cfg_div changed from 100 to 2 while pre_cnt=50 → tick next cycle, then every 3 cycles.
- snap_req in a tick cycle → snap_data equals the post-tick ch_val. Second snap_req before snap_ack → snap_data unchanged. After snap_ack, snap_valid=0 next cycle.
- cnt_reset asserted with snap_valid=1 and counters nonzero → all outputs 0 next cycle.

Source files
------------

// File: rtl/cnt_pkg.sv
// cnt_pkg: shared mode encodings, default widths and channel slice helper for cnt_multi_timer
package cnt_pkg;
    localparam logic CNT_MODE_FREE   = 1'b0;
    localparam logic CNT_MODE_RELOAD = 1'b1;
    localparam int CNT_W_DEF = 32;
    localparam int PRE_W_DEF = 16;
    localparam int N_CH_DEF  = 4;
    function automatic int ch_lo(input int i, input int w);
        return i * w;
    endfunction
endpackage

// File: rtl/cnt_prescaler.sv
// cnt_prescaler: shared runtime-programmable divider, hit once every cfg_div+1 cycles
// ports: cnt_clk, cnt_reset (sync, active-high), cfg_div (divider), hit (combinational, registered by the top)
module cnt_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             cnt_clk,
    input  logic             cnt_reset,
    input  logic [PRE_W-1:0] cfg_div,
    output logic             hit
);
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    // >= lets a divider lowered below the running count take effect at once
    always_comb begin
        hit       = pre_cnt_q >= cfg_div;
        pre_cnt_d = hit ? '0 : pre_cnt_q + 1'b1;
    end
    always_ff @(posedge cnt_clk) begin
        if (cnt_reset) pre_cnt_q <= '0;
        else           pre_cnt_q <= pre_cnt_d;
    end
endmodule

// File: rtl/cnt_multi_timer.sv
// cnt_multi_timer: N_CH tick counters on a shared prescaler with compare, auto-reload, sticky overflow and atomic snapshot
// ports: cnt_clk/cnt_reset, cfg_div, per-channel ch_en/ch_clr/ch_mode/ch_cmp in; tick, ch_val/ch_match/ch_ovf out;
//        snap_req/snap_ack in, snap_valid/snap_data out
module cnt_multi_timer import cnt_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRE_W = PRE_W_DEF,
    parameter int N_CH  = N_CH_DEF
) (
    input  logic                    cnt_clk,
    input  logic                    cnt_reset,
    input  logic [PRE_W-1:0]        cfg_div,
    input  logic [N_CH-1:0]         ch_en,
    input  logic [N_CH-1:0]         ch_clr,
    input  logic [N_CH-1:0]         ch_mode,
    input  logic [N_CH*CNT_W-1:0]   ch_cmp,
    output logic                    tick,
    output logic [N_CH*CNT_W-1:0]   ch_val,
    output logic [N_CH-1:0]         ch_match,
    output logic [N_CH-1:0]         ch_ovf,
    input  logic                    snap_req,
    output logic                    snap_valid,
    output logic [N_CH*CNT_W-1:0]   snap_data,
    input  logic                    snap_ack
);
    logic                  hit, tick_q, snap_valid_q, snap_valid_d;
    logic [N_CH*CNT_W-1:0] val_nxt, snap_data_q, snap_data_d;
    cnt_prescaler #(.PRE_W(PRE_W)) u_pre (
        .cnt_clk   (cnt_clk),
        .cnt_reset (cnt_reset),
        .cfg_div   (cfg_div),
        .hit       (hit)
    );
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [CNT_W-1:0] val_q, val_d, cmp, inc;
        logic             match_q, match_d, ovf_q, ovf_d;
        assign cmp = ch_cmp[ch_lo(c, CNT_W) +: CNT_W];
        assign inc = val_q + 1'b1;
        always_comb begin
            val_d   = val_q;
            match_d = 1'b0;
            ovf_d   = ovf_q;
            if (ch_clr[c]) begin
                val_d = '0;
                ovf_d = 1'b0;
            end else if (hit && ch_en[c]) begin
                if (ch_mode[c] == CNT_MODE_RELOAD && val_q == cmp) begin
                    val_d   = '0;
                    match_d = 1'b1;
                end else begin
                    val_d   = inc;
                    match_d = ch_mode[c] == CNT_MODE_FREE && inc == cmp;
                    ovf_d   = ovf_q | (&val_q);
                end
            end
        end
        always_ff @(posedge cnt_clk) begin
            if (cnt_reset) begin
                val_q   <= '0;
                match_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                val_q   <= val_d;
                match_q <= match_d;
                ovf_q   <= ovf_d;
            end
        end
        assign val_nxt[ch_lo(c, CNT_W) +: CNT_W] = val_d;
        assign ch_val[ch_lo(c, CNT_W) +: CNT_W]  = val_q;
        assign ch_match[c] = match_q;
        assign ch_ovf[c]   = ovf_q;
    end
    // snapshot captures next-state values so it agrees with ch_val in the following cycle
    always_comb begin
        snap_valid_d = snap_valid_q ? !snap_ack : snap_req;
        snap_data_d  = (!snap_valid_q && snap_req) ? val_nxt : snap_data_q;
    end
    always_ff @(posedge cnt_clk) begin
        if (cnt_reset) begin
            tick_q       <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_data_q  <= '0;
        end else begin
            tick_q       <= hit;
            snap_valid_q <= snap_valid_d;
            snap_data_q  <= snap_data_d;
        end
    end
    assign tick       = tick_q;
    assign snap_valid = snap_valid_q;
    assign snap_data  = snap_data_q;
endmodule

// File: tb/tb_cnt_multi_timer.sv
// tb_cnt_multi_timer: vector table, directed corner sequences and random run against a behavioural model
module tb_cnt_multi_timer;
    logic        cnt_clk = 1'b0, cnt_reset, tick, snap_req, snap_valid, snap_ack;
    logic [7:0]  cfg_div;
    logic [3:0]  ch_en, ch_clr, ch_mode, ch_match, ch_ovf;
    logic [31:0] ch_cmp, ch_val, snap_data;
    cnt_multi_timer #(.CNT_W(8), .PRE_W(8), .N_CH(4)) dut (
        .cnt_clk    (cnt_clk),
        .cnt_reset  (cnt_reset),
        .cfg_div    (cfg_div),
        .ch_en      (ch_en),
        .ch_clr     (ch_clr),
        .ch_mode    (ch_mode),
        .ch_cmp     (ch_cmp),
        .tick       (tick),
        .ch_val     (ch_val),
        .ch_match   (ch_match),
        .ch_ovf     (ch_ovf),
        .snap_req   (snap_req),
        .snap_valid (snap_valid),
        .snap_data  (snap_data),
        .snap_ack   (snap_ack)
    );
    always #5 cnt_clk = ~cnt_clk;
    int n_chk = 0, n_pass = 0;
    int m_pre = 0;
    int m_val[4] = '{0, 0, 0, 0};
    logic m_tick = 1'b0, m_sv = 1'b0;
    logic [3:0] m_match = '0, m_ovf = '0;
    logic [31:0] m_sd = '0;
    typedef struct {
        logic rst; logic [3:0] en; logic [3:0] mode; logic [7:0] div; logic [7:0] cmp0;
        logic tick; logic [7:0] val0; logic match0; logic ovf0;
    } vec_t;
    vec_t vecs[$];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    function automatic logic [31:0] pack_val();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(m_val[i]);
        return r;
    endfunction
    task automatic model_step();
        logic hit;
        logic old_sv;
        int cmp;
        old_sv = m_sv;
        if (cnt_reset) begin
            m_pre = 0; m_tick = 0; m_match = 0; m_ovf = 0; m_sv = 0; m_sd = 0;
            for (int i = 0; i < 4; i++) m_val[i] = 0;
            return;
        end
        hit = m_pre >= int'(cfg_div);
        m_pre = hit ? 0 : m_pre + 1;
        m_tick = hit;
        for (int i = 0; i < 4; i++) begin
            cmp = int'(ch_cmp[i*8 +: 8]);
            m_match[i] = 1'b0;
            if (ch_clr[i]) begin
                m_val[i] = 0;
                m_ovf[i] = 1'b0;
            end else if (hit && ch_en[i]) begin
                if (ch_mode[i] && m_val[i] == cmp) begin
                    m_val[i] = 0;
                    m_match[i] = 1'b1;
                end else begin
                    if (m_val[i] == 255) m_ovf[i] = 1'b1;
                    m_val[i] = (m_val[i] + 1) % 256;
                    m_match[i] = !ch_mode[i] && m_val[i] == cmp;
                end
            end
        end
        if (!old_sv && snap_req) begin
            m_sv = 1'b1;
            m_sd = pack_val();
        end else if (old_sv && snap_ack) m_sv = 1'b0;
    endtask
    task automatic cyc();
        model_step();
        @(posedge cnt_clk);
        #1;
        chk("tick", tick, m_tick);
        chk("ch_val", ch_val, pack_val());
        chk("ch_match", ch_match, m_match);
        chk("ch_ovf", ch_ovf, m_ovf);
        chk("snap_valid", snap_valid, m_sv);
        chk("snap_data", snap_data, m_sd);
    endtask
    initial begin
        logic [31:0] saved;
        cnt_reset = 1; cfg_div = 0; ch_en = 0; ch_clr = 0; ch_mode = 0; ch_cmp = 0;
        snap_req = 0; snap_ack = 0;
        vecs.push_back('{1, 0, 0, 3, 200, 0, 0, 0, 0});
        for (int k = 1; k <= 12; k++)
            vecs.push_back('{0, 4'b0001, 4'b0000, 3, 200, (k % 4) == 0, 8'(k / 4), 0, 0});
        vecs.push_back('{1, 0, 0, 0, 2, 0, 0, 0, 0});
        for (int k = 1; k <= 6; k++)
            vecs.push_back('{0, 4'b0001, 4'b0001, 0, 2, 1, 8'(k % 3), (k % 3) == 0, 0});
        foreach (vecs[i]) begin
            cnt_reset = vecs[i].rst; ch_en = vecs[i].en; ch_mode = vecs[i].mode;
            cfg_div = vecs[i].div; ch_cmp = {24'd0, vecs[i].cmp0};
            cyc();
            chk("vec_tick", tick, vecs[i].tick);
            chk("vec_val0", ch_val[7:0], vecs[i].val0);
            chk("vec_val_others", ch_val[31:8], 0);
            chk("vec_match0", ch_match[0], vecs[i].match0);
            chk("vec_ovf0", ch_ovf[0], vecs[i].ovf0);
        end
        // wrap sets sticky overflow; clear beats a simultaneous tick and match
        cnt_reset = 1; cyc();
        cnt_reset = 0; cfg_div = 0; ch_en = 4'b0001; ch_mode = 0; ch_cmp = 32'd5;
        repeat (255) cyc();
        chk("wrap_pre_val", ch_val[7:0], 255);
        chk("wrap_pre_ovf", ch_ovf[0], 0);
        cyc();
        chk("wrap_val", ch_val[7:0], 0);
        chk("wrap_ovf", ch_ovf[0], 1);
        repeat (4) cyc();
        chk("ovf_sticky", ch_ovf[0], 1);
        chk("ovf_sticky_val", ch_val[7:0], 4);
        ch_clr = 4'b0001; cyc(); ch_clr = 0;
        chk("clr_val", ch_val[7:0], 0);
        chk("clr_match", ch_match[0], 0);
        chk("clr_ovf", ch_ovf[0], 0);
        chk("clr_tick", tick, 1);
        // divider lowered below running count
        cnt_reset = 1; cyc();
        cnt_reset = 0; cfg_div = 100; ch_en = 0;
        repeat (50) cyc();
        chk("div_no_tick", tick, 0);
        cfg_div = 2;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk("div_tick", tick, (k % 3) == 1);
        end
        // snapshot coincident with a tick
        cfg_div = 3; ch_en = 4'hF; ch_mode = 0; ch_cmp = 32'h80808080;
        repeat (6) cyc();
        for (int i = 0; i < 10 && m_pre != 3; i++) cyc();
        chk("snap_align", m_pre, 3);
        snap_req = 1; cyc();
        saved = pack_val();
        chk("snap_tick", tick, 1);
        chk("snap_valid_set", snap_valid, 1);
        chk("snap_coherent", snap_data, saved);
        repeat (6) cyc();
        chk("snap_hold", snap_data, saved);
        snap_ack = 1; cyc();
        chk("snap_ack_clr", snap_valid, 0);
        chk("snap_ack_data", snap_data, saved);
        snap_ack = 0; snap_req = 0; cyc();
        chk("snap_idle", snap_valid, 0);
        // reset while a snapshot is held
        repeat (5) cyc();
        snap_req = 1; cyc(); snap_req = 0;
        chk("rst_pre_valid", snap_valid, 1);
        chk("rst_pre_nonzero", ch_val != 0, 1);
        cnt_reset = 1; cyc(); cnt_reset = 0;
        chk("rst_tick", tick, 0);
        chk("rst_val", ch_val, 0);
        chk("rst_match", ch_match, 0);
        chk("rst_ovf", ch_ovf, 0);
        chk("rst_snap_valid", snap_valid, 0);
        chk("rst_snap_data", snap_data, 0);
        // random traffic
        repeat (3000) begin
            cnt_reset = $urandom_range(0, 199) == 0;
            if ($urandom_range(0, 19) == 0) cfg_div = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) ch_en = 4'($urandom);
            if ($urandom_range(0, 49) == 0) ch_mode = 4'($urandom);
            if ($urandom_range(0, 29) == 0)
                for (int i = 0; i < 4; i++) ch_cmp[i*8 +: 8] = 8'($urandom_range(0, 40));
            for (int i = 0; i < 4; i++) ch_clr[i] = $urandom_range(0, 15) == 0;
            snap_req = $urandom_range(0, 3) == 0;
            snap_ack = $urandom_range(0, 3) == 0;
            cyc();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
